// File: rtl/mem_stage_pkg.sv
// Shared widths, state encoding and address helpers for the memory-access stage.
package mem_stage_pkg;

    localparam int REG_DATA_W      = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W           = 8;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_misaligned(input logic [REG_DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB boundary register: captures a retiring result or inserts a bubble.
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_i,
    input  logic                  bubble_i,
    input  logic                  write_reg_i,
    input  logic [REG_DATA_W-1:0] reg_data_i,
    input  logic [REG_ADDR_W-1:0] des_r_i,
    output logic                  write_reg_o,
    output logic [REG_DATA_W-1:0] reg_data_o,
    output logic [REG_ADDR_W-1:0] des_r_o
);

    logic                  write_reg_q;
    logic [REG_DATA_W-1:0] reg_data_q;
    logic [REG_ADDR_W-1:0] des_r_q;

    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            write_reg_q <= 1'b0;
            reg_data_q  <= '0;
            des_r_q     <= '0;
        end else if (capture_i) begin
            write_reg_q <= write_reg_i;
            reg_data_q  <= reg_data_i;
            des_r_q     <= des_r_i;
        end
    end

    assign write_reg_o = write_reg_q;
    assign reg_data_o  = reg_data_q;
    assign des_r_o     = des_r_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack port,
// upstream stall while outstanding, misalignment and timeout exceptions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MEM_IDLE | no access outstanding; non-access results retire directly
// MEM_WAIT | dmem_req held high, counting cycles until ack or timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_write_reg,
    input  logic                  mem_mem_to_reg,
    input  logic                  mem_write_mem,
    input  logic [REG_DATA_W-1:0] alu_result,
    input  logic [REG_DATA_W-1:0] write_mem_val,
    input  logic [REG_ADDR_W-1:0] m_des_r,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [REG_DATA_W-1:0] dmem_addr,
    output logic [REG_DATA_W-1:0] dmem_wdata,
    input  logic [REG_DATA_W-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  mem_stall,
    output logic                  wb_write_reg,
    output logic [REG_DATA_W-1:0] wb_reg_data,
    output logic [REG_ADDR_W-1:0] wb_des_r,
    output logic                  mem_exc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  req_q;
    logic                  we_q;
    logic [REG_DATA_W-1:0] addr_q;
    logic [REG_DATA_W-1:0] wdata_q;
    logic [REG_ADDR_W-1:0] des_q;
    logic                  load_q;
    logic                  exc_q;

    logic                  access;
    logic                  misaligned;
    logic                  expire;
    logic                  wb_capture;
    logic                  wb_write_d;
    logic [REG_DATA_W-1:0] wb_data_d;
    logic [REG_ADDR_W-1:0] wb_des_d;

    always_comb begin
        access     = mem_mem_to_reg | mem_write_mem;
        misaligned = is_misaligned(alu_result);
        expire     = (cnt_q == CNT_LAST);

        mem_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                MEM_IDLE: mem_stall = access && !misaligned;
                MEM_WAIT: mem_stall = !dmem_ack && !expire;
                default:  mem_stall = 1'b0;
            endcase
        end
    end

    // Only two things ever retire a real result; everything else is a bubble.
    always_comb begin
        wb_capture = 1'b0;
        wb_write_d = 1'b0;
        wb_data_d  = '0;
        wb_des_d   = '0;
        if (state_q == MEM_IDLE && !access) begin
            wb_capture = 1'b1;
            wb_write_d = mem_write_reg;
            wb_data_d  = alu_result;
            wb_des_d   = m_des_r;
        end else if (state_q == MEM_WAIT && dmem_ack && load_q) begin
            wb_capture = 1'b1;
            wb_write_d = 1'b1;
            wb_data_d  = dmem_rdata;
            wb_des_d   = des_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            des_q   <= '0;
            load_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            exc_q <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (access && misaligned) begin
                        exc_q <= 1'b1;
                    end else if (access) begin
                        state_q <= MEM_WAIT;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= mem_write_mem;
                        addr_q  <= alu_result;
                        wdata_q <= write_mem_val;
                        des_q   <= m_des_r;
                        // a combined load+store behaves as a store
                        load_q  <= mem_mem_to_reg && !mem_write_mem;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_q <= MEM_IDLE;
                        req_q   <= 1'b0;
                    end else if (expire) begin
                        state_q <= MEM_IDLE;
                        req_q   <= 1'b0;
                        exc_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= MEM_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_exc    = exc_q;

    mem_wb u_mem_wb (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (wb_capture),
        .bubble_i    (!wb_capture),
        .write_reg_i (wb_write_d),
        .reg_data_i  (wb_data_d),
        .des_r_i     (wb_des_d),
        .write_reg_o (wb_write_reg),
        .reg_data_o  (wb_reg_data),
        .des_r_o     (wb_des_r)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions checked against a transaction-level expectation model.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write_reg = 1'b0;
    logic        mem_mem_to_reg = 1'b0;
    logic        mem_write_mem = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] write_mem_val = '0;
    logic [4:0]  m_des_r = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        mem_stall;
    logic        wb_write_reg;
    logic [31:0] wb_reg_data;
    logic [4:0]  wb_des_r;
    logic        mem_exc;

    int n_cmp = 0;
    int n_err = 0;

    // observations from the last executed instruction
    int          o_stall, o_req, o_lat;
    logic        o_we, o_wr, o_exc, o_req_after;
    logic [31:0] o_addr, o_wdata, o_data;
    logic [4:0]  o_des;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .mem_write_reg(mem_write_reg), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_write_mem(mem_write_mem), .alu_result(alu_result),
        .write_mem_val(write_mem_val), .m_des_r(m_des_r),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .wb_write_reg(wb_write_reg),
        .wb_reg_data(wb_reg_data), .wb_des_r(wb_des_r), .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        mem_write_reg  = 1'b0;
        mem_mem_to_reg = 1'b0;
        mem_write_mem  = 1'b0;
        alu_result     = '0;
        write_mem_val  = '0;
        m_des_r        = '0;
    endtask

    // Drives one instruction (called just after a rising edge), holds it while
    // stalled, answers the memory with an ack in WAIT cycle ack_at (-1 = never).
    task automatic exec(input logic wr, input logic ld, input logic st,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] des, input int ack_at,
                        input logic [31:0] rdata);
        int   w;
        bit   done;
        logic stall_s;
        mem_write_reg = wr; mem_mem_to_reg = ld; mem_write_mem = st;
        alu_result = alu; write_mem_val = wd; m_des_r = des;
        o_stall = 0; o_req = 0; o_lat = 0;
        o_we = 1'b0; o_addr = '0; o_wdata = '0;
        w = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (dmem_req) begin
                if (w == 0) begin
                    o_we = dmem_we; o_addr = dmem_addr; o_wdata = dmem_wdata;
                end
                dmem_ack   = (w == ack_at);
                dmem_rdata = rdata;
                w++;
                o_req++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            stall_s = mem_stall;
            if (stall_s) o_stall++;
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom();
            o_lat = c + 1;
            if (!stall_s) done = 1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL exec_budget: instruction still stalled after %0d cycles, required completion", o_lat);
        end
        o_wr = wb_write_reg; o_data = wb_reg_data; o_des = wb_des_r;
        o_exc = mem_exc; o_req_after = dmem_req;
        set_nop();
    endtask

    task automatic test_reset();
        mem_mem_to_reg = 1'b1; alu_result = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
        n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin n_err++; $display("FAIL rst_dmem: got req=%b we=%b addr=%h wdata=%h want zeros", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
        n_cmp++; if ({wb_write_reg, wb_reg_data, wb_des_r, mem_exc} !== '0) begin n_err++; $display("FAIL rst_wb: got wr=%b data=%h des=%0d exc=%b want zeros", wb_write_reg, wb_reg_data, wb_des_r, mem_exc); end
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
    endtask

    task automatic test_alu();
        exec(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, -1, 32'h0);
        n_cmp++; if (o_wr !== 1'b1) begin n_err++; $display("FAIL alu_wr: got %b want 1", o_wr); end
        n_cmp++; if (o_data !== 32'h1234) begin n_err++; $display("FAIL alu_data: got %h want 00001234", o_data); end
        n_cmp++; if (o_des !== 5'd5) begin n_err++; $display("FAIL alu_des: got %0d want 5", o_des); end
        n_cmp++; if (o_stall != 0 || o_lat != 1) begin n_err++; $display("FAIL alu_timing: got stall=%0d lat=%0d want 0/1", o_stall, o_lat); end
    endtask

    task automatic test_load();
        exec(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 3, 32'hDEAD_BEEF);
        n_cmp++; if (o_stall != 4) begin n_err++; $display("FAIL load_stall: got %0d want 4", o_stall); end
        n_cmp++; if (o_req != 4 || o_req_after !== 1'b0) begin n_err++; $display("FAIL load_req: got %0d cycles, after=%b want 4/0", o_req, o_req_after); end
        n_cmp++; if (o_we !== 1'b0 || o_addr !== 32'h100) begin n_err++; $display("FAIL load_port: got we=%b addr=%h want 0/00000100", o_we, o_addr); end
        n_cmp++; if (o_wr !== 1'b1 || o_data !== 32'hDEAD_BEEF || o_des !== 5'd9) begin n_err++; $display("FAIL load_wb: got wr=%b data=%h des=%0d want 1/deadbeef/9", o_wr, o_data, o_des); end
        n_cmp++; if (o_exc !== 1'b0) begin n_err++; $display("FAIL load_exc: got %b want 0", o_exc); end
    endtask

    task automatic test_store();
        exec(1'b0, 1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 5'd3, 0, 32'h5555_AAAA);
        n_cmp++; if (o_we !== 1'b1 || o_addr !== 32'h204 || o_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL store_port: got we=%b addr=%h wdata=%h want 1/00000204/cafef00d", o_we, o_addr, o_wdata); end
        n_cmp++; if (o_lat != 2 || o_req != 1) begin n_err++; $display("FAIL store_timing: got lat=%0d req=%0d want 2/1", o_lat, o_req); end
        n_cmp++; if (o_wr !== 1'b0 || o_exc !== 1'b0) begin n_err++; $display("FAIL store_wb: got wr=%b exc=%b want 0/0", o_wr, o_exc); end
    endtask

    task automatic test_misaligned();
        exec(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 0, 32'h1111_1111);
        n_cmp++; if (o_req != 0 || o_stall != 0 || o_lat != 1) begin n_err++; $display("FAIL mis_timing: got req=%0d stall=%0d lat=%0d want 0/0/1", o_req, o_stall, o_lat); end
        n_cmp++; if (o_exc !== 1'b1 || o_wr !== 1'b0) begin n_err++; $display("FAIL mis_exc: got exc=%b wr=%b want 1/0", o_exc, o_wr); end
        @(posedge clk); #1;
        n_cmp++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got exc=%b one cycle later want 0", mem_exc); end
    endtask

    task automatic test_timeout();
        exec(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd6, -1, 32'h0);
        n_cmp++; if (o_req != T || o_stall != T || o_lat != T + 1) begin n_err++; $display("FAIL to_timing: got req=%0d stall=%0d lat=%0d want %0d/%0d/%0d", o_req, o_stall, o_lat, T, T, T + 1); end
        n_cmp++; if (o_exc !== 1'b1 || o_wr !== 1'b0 || o_req_after !== 1'b0) begin n_err++; $display("FAIL to_result: got exc=%b wr=%b req=%b want 1/0/0", o_exc, o_wr, o_req_after); end
        @(posedge clk); #1;
        n_cmp++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL to_pulse: got exc=%b want 0", mem_exc); end
    endtask

    task automatic test_ack_on_expiry();
        exec(1'b0, 1'b1, 1'b0, 32'h7F0, 32'h0, 5'd17, T - 1, 32'h0BAD_F00D);
        n_cmp++; if (o_exc !== 1'b0 || o_wr !== 1'b1 || o_data !== 32'h0BAD_F00D || o_des !== 5'd17) begin n_err++; $display("FAIL expiry_ack: got exc=%b wr=%b data=%h des=%0d want 0/1/0badf00d/17", o_exc, o_wr, o_data, o_des); end
    endtask

    task automatic test_reset_mid_wait();
        mem_mem_to_reg = 1'b1; alu_result = 32'h300; m_des_r = 5'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rmw_pre: got req=%b want 1", dmem_req); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rmw_stall: got %b want 0", mem_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_write_reg, wb_reg_data, wb_des_r, mem_exc} !== '0) begin n_err++; $display("FAIL rmw_zero: got req=%b we=%b addr=%h wd=%h wr=%b data=%h des=%0d exc=%b want zeros", dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_write_reg, wb_reg_data, wb_des_r, mem_exc); end
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_cmp++; if (dmem_req !== 1'b0 || wb_write_reg !== 1'b0 || mem_exc !== 1'b0) begin n_err++; $display("FAIL rmw_late_ack: got req=%b wr=%b exc=%b want 0/0/0", dmem_req, wb_write_reg, mem_exc); end
        exec(1'b1, 1'b0, 1'b0, 32'h0000_ABCD, 32'h0, 5'd12, -1, 32'h0);
        n_cmp++; if (o_wr !== 1'b1 || o_data !== 32'hABCD || o_des !== 5'd12 || o_stall != 0) begin n_err++; $display("FAIL rmw_alu: got wr=%b data=%h des=%0d stall=%0d want 1/0000abcd/12/0", o_wr, o_data, o_des, o_stall); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        wr, ld, st, e_wr, e_exc;
            logic [31:0] alu, wd, rd, e_data;
            logic [4:0]  des;
            int          ack_at, e_lat, e_stall, e_req;
            wr = 1'($urandom()); ld = 1'($urandom()); st = 1'($urandom());
            alu = $urandom(); wd = $urandom(); rd = $urandom(); des = 5'($urandom());
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            ack_at = int'($urandom_range(0, 5)) - 1;
            // expected outcome from the stage's architectural rules
            if (!(ld || st)) begin
                e_wr = wr; e_data = alu; e_exc = 0; e_lat = 1; e_stall = 0; e_req = 0;
            end else if (alu % 4 != 0) begin
                e_wr = 0; e_data = 0; e_exc = 1; e_lat = 1; e_stall = 0; e_req = 0;
            end else if (ack_at >= 0 && ack_at < T) begin
                e_wr = ld && !st; e_data = rd; e_exc = 0;
                e_lat = ack_at + 2; e_stall = ack_at + 1; e_req = ack_at + 1;
            end else begin
                e_wr = 0; e_data = 0; e_exc = 1; e_lat = T + 1; e_stall = T; e_req = T;
            end
            exec(wr, ld, st, alu, wd, des, ack_at, rd);
            n_cmp++; if (o_wr !== e_wr || o_exc !== e_exc) begin n_err++; $display("FAIL rnd%0d_flags: got wr=%b exc=%b want %b/%b", i, o_wr, o_exc, e_wr, e_exc); end
            n_cmp++; if (o_lat != e_lat || o_stall != e_stall || o_req != e_req) begin n_err++; $display("FAIL rnd%0d_timing: got lat=%0d stall=%0d req=%0d want %0d/%0d/%0d", i, o_lat, o_stall, o_req, e_lat, e_stall, e_req); end
            if (e_wr) begin
                n_cmp++; if (o_data !== e_data || o_des !== des) begin n_err++; $display("FAIL rnd%0d_wb: got data=%h des=%0d want %h/%0d", i, o_data, o_des, e_data, des); end
            end
            if (e_req > 0) begin
                n_cmp++; if (o_we !== st || o_addr !== alu || o_wdata !== wd) begin n_err++; $display("FAIL rnd%0d_port: got we=%b addr=%h wd=%h want %b/%h/%h", i, o_we, o_addr, o_wdata, st, alu, wd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_on_expiry();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM register. It consumes the control flags, ALU result, store data and destination register that EX/MEM presents. It performs word loads and stores over a request/acknowledge data-memory port, stalls the upstream pipeline while an access is outstanding, and registers the write-back result into the MEM/WB boundary. It also detects misaligned addresses and memory timeouts.

## Interface
- TIMEOUT, 15: maximum cycles in WAIT without dmem_ack before the access is abandoned; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_write_reg  in  1  instruction writes a register.
- mem_mem_to_reg  in  1  instruction is a load.
- mem_write_mem  in  1  instruction is a store.
- alu_result  in  `RegDataBus (32)  effective address, or the result for non-memory instructions.
- write_mem_val  in  32  store data.
- m_des_r  in  `RegAddrBus (5)  destination register.
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  1 = store; registered.
- dmem_addr  out  32  word address; registered.
- dmem_wdata  out  32  store data; registered.
- dmem_rdata  in  32  load data; valid when dmem_ack = 1.
- dmem_ack  in  1  access complete; single-cycle pulse.
- mem_stall  out  1  hold EX/MEM and all earlier stages; combinational.
- wb_write_reg  out  1  MEM/WB register-write enable.
- wb_reg_data  out  32  MEM/WB write-back data.
- wb_des_r  out  5  MEM/WB destination register.
- mem_exc  out  1  one-cycle pulse on a misaligned access or a timeout.

## Operation
- Access: mem_mem_to_reg | mem_write_mem. If both are set, the instruction is treated as a store and no register is written.
- State machine states are IDLE and WAIT.
- IDLE, non-access instruction: MEM/WB captures wb_write_reg = mem_write_reg, wb_reg_data = alu_result, wb_des_r = m_des_r. Stall is 0.
- IDLE, access with alu_result[1:0] != 0 (misaligned):
  - No request is issued.
  - Next edge: wb_write_reg = 0 and mem_exc = 1 for one cycle.
  - Stall is 0.
- IDLE, aligned access:
  - mem_stall = 1.
  - Next edge: dmem_req = 1, and dmem_we/addr/wdata, the destination and the load flag are latched. The state moves to WAIT, MEM/WB captures a bubble (wb_write_reg = 0), and the timeout counter is cleared to 0.
- WAIT, no dmem_ack: mem_stall = 1 and the counter increments.
  - Counter == TIMEOUT-1: next edge drops dmem_req, returns to IDLE, pulses mem_exc and loads a bubble into MEM/WB.
  - mem_stall deasserts in that final cycle, so the instruction retires as a bubble.
- WAIT, dmem_ack = 1: mem_stall = 0 in the same cycle. Next edge:
  - dmem_req drops and the state returns to IDLE.
  - For a load: wb_write_reg = 1, wb_reg_data = dmem_rdata, wb_des_r = latched destination.
  - For a store: wb_write_reg = 0.
- dmem_ack in the same cycle as timeout expiry: the ack wins and no exception is raised.
- dmem_ack outside WAIT is ignored.
- Register 0 is passed through unchanged; write-back suppresses writes to it.

## Timing
- Non-access and misaligned instructions: 1-cycle latency into MEM/WB.
- Aligned access: latency 1 + (cycles in WAIT until ack). The minimum is 2 cycles, when ack arrives in the first WAIT cycle.
- Maximum access latency is 1 + TIMEOUT cycles, ending with an exception.
- While mem_stall = 1, upstream inputs are stable; the stage still uses its latched copies.
- Reset, including mid-WAIT, forces on the next edge:
  - state = IDLE, counter = 0;
  - dmem_req = dmem_we = 0, dmem_addr = dmem_wdata = 0;
  - wb_write_reg = 0, wb_reg_data = 0, wb_des_r = 0, mem_exc = 0.
- mem_stall is 0 while rst = 1.
- A late dmem_ack after reset is ignored.

## Structure
- macros.v holds `RegDataBus, `RegAddrBus, the state encodings `MemIdle / `MemWait, and the default `MemTimeout.
- One sub-module, mem_wb: the MEM/WB output register, with synchronous reset and a bubble-insert input.
- The FSM, timeout counter and request registers live in mem_stage.

## Test plan
- ALU op with alu_result = 0x0000_1234, mem_write_reg = 1, des = 5 -> the next cycle shows wb_write_reg = 1, wb_reg_data = 0x1234, wb_des_r = 5, and stall never asserts.
- Load from 0x100, ack 3 cycles after dmem_req rises with rdata = 0xDEAD_BEEF -> mem_stall is high for 4 cycles, then wb_reg_data = 0xDEAD_BEEF, des correct, exactly one dmem_req burst.
- Store 0xCAFE_F00D to 0x204, ack in the first WAIT cycle -> dmem_we = 1, dmem_addr = 0x204, dmem_wdata = 0xCAFE_F00D, 2-cycle latency, wb_write_reg = 0.
- Load at 0x102 -> no dmem_req, mem_exc pulses 1 cycle, wb_write_reg = 0, no stall.
- Load with no ack, TIMEOUT = 4 -> dmem_req is high for 4 cycles, then mem_exc pulses and a bubble is retired. A second test has ack arrive on the expiry cycle -> normal completion, no mem_exc.
- rst asserted in the 2nd WAIT cycle, ack arriving 1 cycle later -> all outputs are zero after the reset edge, the ack is ignored, and the next ALU op passes normally.
